data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 41 ++++
 tb/tb_data_memory.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed RAM with synchronous write and combinational read.
// Optional macro DATA_MEMORY_RESET_CLEAR_EN: reset clears every word in one cycle.
module data_memory #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ADDR_DATA_M,
    input  logic              Mem_WE,
    input  logic [DATA_W-1:0] IN_DATA_M,
    output logic [DATA_W-1:0] OUT_DATA_M
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef DATA_MEMORY_RESET_CLEAR_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (Mem_WE) begin
            mem_q[ADDR_DATA_M] <= IN_DATA_M;
        end
    end
`else
    // Reset leaves contents alone but still blocks a write on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST && Mem_WE) begin
            mem_q[ADDR_DATA_M] <= IN_DATA_M;
        end
    end
`endif

    // No bypass: a same-address write shows up only after its edge.
    assign OUT_DATA_M = mem_q[ADDR_DATA_M];

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expectations follow
// DATA_MEMORY_RESET_CLEAR_EN when the macro is defined.
module tb_data_memory;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [ADDR_W-1:0] ADDR_DATA_M = '0;
    logic              Mem_WE = 1'b0;
    logic [DATA_W-1:0] IN_DATA_M = '0;
    logic [DATA_W-1:0] OUT_DATA_M;

    int checks = 0;
    int failures = 0;

    data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADDR_DATA_M(ADDR_DATA_M),
        .Mem_WE     (Mem_WE),
        .IN_DATA_M  (IN_DATA_M),
        .OUT_DATA_M (OUT_DATA_M)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after a rising edge, away from the sampling edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ADDR_DATA_M = a;
        IN_DATA_M   = d;
        Mem_WE      = 1'b1;
        @(posedge CLK);
        #1;
        Mem_WE      = 1'b0;
    endtask

    task automatic pulse_reset(input logic we, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
        RST         = 1'b1;
        Mem_WE      = we;
        ADDR_DATA_M = a;
        IN_DATA_M   = d;
        @(posedge CLK);
        #1;
        RST         = 1'b0;
        Mem_WE      = 1'b0;
    endtask

    task automatic test_reset;
        logic [DATA_W-1:0] exp;
        do_write(8'h05, 32'h11223344);
        pulse_reset(1'b0, 8'h05, 32'h0);
`ifdef DATA_MEMORY_RESET_CLEAR_EN
        exp = 32'h0;
`else
        exp = 32'h11223344;
`endif
        ADDR_DATA_M = 8'h05;
        #1;
        checks++;
        if (OUT_DATA_M !== exp) begin
            failures++;
            $display("FAIL reset_state addr=05 got=%h exp=%h", OUT_DATA_M, exp);
        end
    endtask

    task automatic test_write_read;
        do_write(8'h00, 32'h0000000F);
        do_write(8'h01, 32'h00000001);
        ADDR_DATA_M = 8'h01;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h00000001) begin
            failures++;
            $display("FAIL write_read addr=01 got=%h exp=%h", OUT_DATA_M, 32'h00000001);
        end
        ADDR_DATA_M = 8'h00;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h0000000F) begin
            failures++;
            $display("FAIL write_read addr=00 got=%h exp=%h", OUT_DATA_M, 32'h0000000F);
        end
    endtask

    task automatic test_read_before_edge;
        do_write(8'h10, 32'hAAAA5555);
        ADDR_DATA_M = 8'h10;
        IN_DATA_M   = 32'h12345678;
        Mem_WE      = 1'b1;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL read_before_edge got=%h exp=%h", OUT_DATA_M, 32'hAAAA5555);
        end
        @(posedge CLK);
        #1;
        Mem_WE = 1'b0;
        checks++;
        if (OUT_DATA_M !== 32'h12345678) begin
            failures++;
            $display("FAIL read_after_edge got=%h exp=%h", OUT_DATA_M, 32'h12345678);
        end
    endtask

    task automatic test_write_disabled;
        Mem_WE      = 1'b0;
        IN_DATA_M   = 32'hDEADBEEF;
        ADDR_DATA_M = 8'h01;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h00000001) begin
            failures++;
            $display("FAIL write_disabled addr=01 got=%h exp=%h", OUT_DATA_M, 32'h00000001);
        end
        ADDR_DATA_M = 8'h00;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h0000000F) begin
            failures++;
            $display("FAIL write_disabled addr=00 got=%h exp=%h", OUT_DATA_M, 32'h0000000F);
        end
    endtask

    task automatic test_reset_priority;
        logic [DATA_W-1:0] exp_ff;
        logic [DATA_W-1:0] exp_01;
        do_write(8'hFF, 32'h77777777);
        pulse_reset(1'b1, 8'hFF, 32'hFFFFFFFF);
`ifdef DATA_MEMORY_RESET_CLEAR_EN
        exp_ff = 32'h0;
        exp_01 = 32'h0;
`else
        exp_ff = 32'h77777777;
        exp_01 = 32'h00000001;
`endif
        ADDR_DATA_M = 8'hFF;
        #1;
        checks++;
        if (OUT_DATA_M !== exp_ff) begin
            failures++;
            $display("FAIL reset_priority addr=ff got=%h exp=%h", OUT_DATA_M, exp_ff);
        end
        ADDR_DATA_M = 8'h01;
        #1;
        checks++;
        if (OUT_DATA_M !== exp_01) begin
            failures++;
            $display("FAIL reset_priority addr=01 got=%h exp=%h", OUT_DATA_M, exp_01);
        end
    endtask

    task automatic test_extremes;
        do_write(8'h80, 32'h5A5A5A5A);
        do_write(8'h00, 32'hCAFEF00D);
        do_write(8'hFF, 32'h0BADBEEF);
        ADDR_DATA_M = 8'h00;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL extremes addr=00 got=%h exp=%h", OUT_DATA_M, 32'hCAFEF00D);
        end
        ADDR_DATA_M = 8'hFF;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h0BADBEEF) begin
            failures++;
            $display("FAIL extremes addr=ff got=%h exp=%h", OUT_DATA_M, 32'h0BADBEEF);
        end
        ADDR_DATA_M = 8'h80;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL extremes addr=80 got=%h exp=%h", OUT_DATA_M, 32'h5A5A5A5A);
        end
    endtask

    task automatic test_back_to_back;
        ADDR_DATA_M = 8'h20;
        IN_DATA_M   = 32'h20202020;
        Mem_WE      = 1'b1;
        @(posedge CLK);
        #1;
        ADDR_DATA_M = 8'h21;
        IN_DATA_M   = 32'h21212121;
        @(posedge CLK);
        #1;
        ADDR_DATA_M = 8'h30;
        IN_DATA_M   = 32'h11111111;
        @(posedge CLK);
        #1;
        IN_DATA_M   = 32'h22222222;
        @(posedge CLK);
        #1;
        Mem_WE = 1'b0;
        checks++;
        if (OUT_DATA_M !== 32'h22222222) begin
            failures++;
            $display("FAIL b2b_same addr=30 got=%h exp=%h", OUT_DATA_M, 32'h22222222);
        end
        ADDR_DATA_M = 8'h20;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h20202020) begin
            failures++;
            $display("FAIL b2b_diff addr=20 got=%h exp=%h", OUT_DATA_M, 32'h20202020);
        end
        ADDR_DATA_M = 8'h21;
        #1;
        checks++;
        if (OUT_DATA_M !== 32'h21212121) begin
            failures++;
            $display("FAIL b2b_diff addr=21 got=%h exp=%h", OUT_DATA_M, 32'h21212121);
        end
    endtask

    task automatic test_reset_clear;
        logic [DATA_W-1:0] pat;
        logic [DATA_W-1:0] exp;
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            pat = {4{i[7:0]}} ^ 32'hA5C3_0F96;
            do_write(i[7:0], pat);
        end
        pulse_reset(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 256; i++) begin
            pat = {4{i[7:0]}} ^ 32'hA5C3_0F96;
`ifdef DATA_MEMORY_RESET_CLEAR_EN
            exp = 32'h0;
`else
            exp = pat;
`endif
            ADDR_DATA_M = i[7:0];
            #1;
            checks++;
            if (OUT_DATA_M !== exp) begin
                failures++;
                bad++;
                if (bad <= 8)
                    $display("FAIL reset_clear addr=%h got=%h exp=%h", i[7:0], OUT_DATA_M, exp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_write_read();
        test_read_before_edge();
        test_write_disabled();
        test_reset_priority();
        // earlier tests may have cleared the array; rebuild state they rely on
        test_write_read();
        test_extremes();
        test_back_to_back();
        test_reset_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
